// File: rtl/vmicro16_apb_rr_arbiter_pkg.sv
// Shared definitions for the vmicro16 shared-APB round-robin arbiter:
// FSM encodings, error/decode defaults and a width helper.
package vmicro16_apb_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_SETUP  = 2'd1,
        ARB_ACCESS = 2'd2,
        ARB_DONE   = 2'd3
    } arb_state_t;

    localparam logic [15:0] ARB_ERR_DATA = 16'hDEAD;
    localparam int          ARB_SEL_LSB  = 12;

    // Index width for n items; never narrower than one bit so n == 1 still elaborates.
    function automatic int arb_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vmicro16_rr_pick.sv
// Combinational round-robin priority encoder: first set request bit found
// searching upward from last+1, wrapping around.
module vmicro16_rr_pick
    import vmicro16_apb_rr_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = arb_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] grant,
    output logic          valid
);

    always_comb begin
        grant = '0;
        valid = 1'b0;
        // Offset N lands back on last itself, so a lone requester that just won is still found.
        for (int i = 1; i <= N; i++) begin
            if (!valid && req[(int'(last) + i) % N]) begin
                valid = 1'b1;
                grant = IW'((int'(last) + i) % N);
            end
        end
    end

endmodule

// File: rtl/vmicro16_apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB slave bus among several core masters,
// with address-decoded slave select, an ACCESS watchdog and error responses.
module vmicro16_apb_rr_arbiter
    import vmicro16_apb_rr_arbiter_pkg::*;
#(
    parameter int                    MASTER_PORTS = 4,
    parameter int                    SLAVE_PORTS  = 8,
    parameter int                    BUS_WIDTH    = 20,
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    SEL_LSB      = ARB_SEL_LSB,
    parameter int                    TIMEOUT      = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA     = DATA_WIDTH'(ARB_ERR_DATA)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [MASTER_PORTS*BUS_WIDTH-1:0]  S_PADDR,
    input  logic [MASTER_PORTS-1:0]            S_PWRITE,
    input  logic [MASTER_PORTS-1:0]            S_PSELx,
    input  logic [MASTER_PORTS-1:0]            S_PENABLE,
    input  logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PWDATA,
    output logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PRDATA,
    output logic [MASTER_PORTS-1:0]            S_PREADY,
    output logic [BUS_WIDTH-1:0]               M_PADDR,
    output logic                               M_PWRITE,
    output logic [SLAVE_PORTS-1:0]             M_PSELx,
    output logic                               M_PENABLE,
    output logic [DATA_WIDTH-1:0]              M_PWDATA,
    input  logic [SLAVE_PORTS*DATA_WIDTH-1:0]  M_PRDATA,
    input  logic [SLAVE_PORTS-1:0]             M_PREADY,
    output logic                               err
);

    localparam int MW = arb_width(MASTER_PORTS);
    localparam int SW = arb_width(SLAVE_PORTS);
    localparam int CW = arb_width(TIMEOUT + 1);
    localparam int TO_LAST_INT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] TO_LAST = CW'(TO_LAST_INT);

    arb_state_t state, state_next;

    logic [MW-1:0]         g_q;
    logic [MW-1:0]         last_grant_q;
    logic [BUS_WIDTH-1:0]  addr_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [SW-1:0]         sidx_q;
    logic [CW-1:0]         cnt_q;
    logic                  err_q;
    logic [MASTER_PORTS-1:0][DATA_WIDTH-1:0] prdata_q;

    logic [MW-1:0]         pick_g;
    logic                  pick_valid;
    logic [BUS_WIDTH-1:0]  pick_addr;
    logic [SW-1:0]         pick_sidx;
    logic                  sidx_ok;
    logic                  slave_ready;
    logic [DATA_WIDTH-1:0] slave_rdata;
    logic                  timed_out;

    // PENABLE from the masters carries no information here; phases are generated locally.
    logic unused_penable;
    assign unused_penable = ^S_PENABLE;

    vmicro16_rr_pick #(
        .N  (MASTER_PORTS),
        .IW (MW)
    ) u_pick (
        .req   (S_PSELx),
        .last  (last_grant_q),
        .grant (pick_g),
        .valid (pick_valid)
    );

    assign pick_addr   = S_PADDR[pick_g*BUS_WIDTH +: BUS_WIDTH];
    assign pick_sidx   = pick_addr[SEL_LSB +: SW];
    assign sidx_ok     = int'(pick_sidx) < SLAVE_PORTS;
    assign slave_ready = M_PREADY[sidx_q];
    assign slave_rdata = M_PRDATA[sidx_q*DATA_WIDTH +: DATA_WIDTH];
    assign timed_out   = (TIMEOUT != 0) && (cnt_q == TO_LAST);
    assign S_PRDATA    = prdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ARB_IDLE;
            g_q          <= '0;
            last_grant_q <= MW'(MASTER_PORTS - 1);
            addr_q       <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            sidx_q       <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            prdata_q     <= '0;
        end else begin
            state <= state_next;
            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        g_q     <= pick_g;
                        addr_q  <= pick_addr;
                        write_q <= S_PWRITE[pick_g];
                        wdata_q <= S_PWDATA[pick_g*DATA_WIDTH +: DATA_WIDTH];
                        sidx_q  <= pick_sidx;
                        cnt_q   <= '0;
                        err_q   <= !sidx_ok;
                        if (!sidx_ok) begin
                            prdata_q[pick_g] <= ERR_DATA;
                        end
                    end
                end
                ARB_ACCESS: begin
                    cnt_q <= cnt_q + 1'b1;
                    // Result is registered on entry to DONE so it is valid alongside S_PREADY.
                    if (slave_ready) begin
                        prdata_q[g_q] <= slave_rdata;
                    end else if (timed_out) begin
                        prdata_q[g_q] <= ERR_DATA;
                        err_q         <= 1'b1;
                    end
                end
                ARB_DONE: begin
                    last_grant_q <= g_q;
                    cnt_q        <= '0;
                    err_q        <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        M_PADDR    = '0;
        M_PWRITE   = 1'b0;
        M_PSELx    = '0;
        M_PENABLE  = 1'b0;
        M_PWDATA   = '0;
        S_PREADY   = '0;
        err        = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_next = sidx_ok ? ARB_SETUP : ARB_DONE;
                end
            end
            ARB_SETUP: begin
                M_PADDR    = addr_q;
                M_PWRITE   = write_q;
                M_PWDATA   = wdata_q;
                M_PSELx    = SLAVE_PORTS'(1) << sidx_q;
                state_next = ARB_ACCESS;
            end
            ARB_ACCESS: begin
                M_PADDR   = addr_q;
                M_PWRITE  = write_q;
                M_PWDATA  = wdata_q;
                M_PSELx   = SLAVE_PORTS'(1) << sidx_q;
                M_PENABLE = 1'b1;
                if (slave_ready || timed_out) begin
                    state_next = ARB_DONE;
                end
            end
            ARB_DONE: begin
                S_PREADY   = MASTER_PORTS'(1) << g_q;
                err        = err_q;
                state_next = ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

endmodule

// File: tb/tb_vmicro16_apb_rr_arbiter.sv
// Self-checking bench for vmicro16_apb_rr_arbiter: cycle vectors for contention and
// a single read, plus hand sequences for wait states, timeout, decode error and reset.
`timescale 1ns/1ps
module tb_vmicro16_apb_rr_arbiter;

    localparam int MP = 4;
    localparam int SP = 6;
    localparam int BW = 20;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset;

    logic [MP*BW-1:0] S_PADDR;
    logic [MP-1:0]    S_PWRITE;
    logic [MP-1:0]    S_PSELx;
    logic [MP-1:0]    S_PENABLE;
    logic [MP*DW-1:0] S_PWDATA;
    logic [MP*DW-1:0] S_PRDATA;
    logic [MP-1:0]    S_PREADY;
    logic [BW-1:0]    M_PADDR;
    logic             M_PWRITE;
    logic [SP-1:0]    M_PSELx;
    logic             M_PENABLE;
    logic [DW-1:0]    M_PWDATA;
    logic [SP*DW-1:0] M_PRDATA;
    logic [SP-1:0]    M_PREADY;
    logic             err;

    logic [BW-1:0] addr [MP];
    logic          wr   [MP];
    logic [DW-1:0] wd   [MP];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [MP-1:0] sel;
        logic [SP-1:0] mready;
        logic [SP-1:0] psel;
        logic          pen;
        logic [MP-1:0] pready;
        logic          err;
    } vec_t;

    vec_t vecs[$];

    vmicro16_apb_rr_arbiter #(
        .MASTER_PORTS (MP),
        .SLAVE_PORTS  (SP),
        .BUS_WIDTH    (BW),
        .DATA_WIDTH   (DW),
        .SEL_LSB      (12),
        .TIMEOUT      (8),
        .ERR_DATA     (16'hDEAD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .S_PADDR   (S_PADDR),
        .S_PWRITE  (S_PWRITE),
        .S_PSELx   (S_PSELx),
        .S_PENABLE (S_PENABLE),
        .S_PWDATA  (S_PWDATA),
        .S_PRDATA  (S_PRDATA),
        .S_PREADY  (S_PREADY),
        .M_PADDR   (M_PADDR),
        .M_PWRITE  (M_PWRITE),
        .M_PSELx   (M_PSELx),
        .M_PENABLE (M_PENABLE),
        .M_PWDATA  (M_PWDATA),
        .M_PRDATA  (M_PRDATA),
        .M_PREADY  (M_PREADY),
        .err       (err)
    );

    always #5 clk = ~clk;

    always_comb begin
        S_PADDR  = '0;
        S_PWRITE = '0;
        S_PWDATA = '0;
        for (int i = 0; i < MP; i++) begin
            S_PADDR[i*BW +: BW]  = addr[i];
            S_PWRITE[i]          = wr[i];
            S_PWDATA[i*DW +: DW] = wd[i];
        end
    end

    assign S_PENABLE = S_PSELx;
    // Slave k read data, slice 0 last.
    assign M_PRDATA  = {16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1234, 16'h0F0F};

    function automatic vec_t mkv(input logic [MP-1:0] sel, input logic [SP-1:0] mready,
                                 input logic [SP-1:0] psel, input logic pen,
                                 input logic [MP-1:0] pready, input logic e);
        vec_t v;
        v.sel = sel; v.mready = mready; v.psel = psel;
        v.pen = pen; v.pready = pready; v.err = e;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        S_PSELx  = v.sel;
        M_PREADY = v.mready;
    endtask

    task automatic checkOutput(input string name, input logic [SP-1:0] psel, input logic pen,
                               input logic [MP-1:0] pready, input logic e);
        checks++;
        if (M_PSELx !== psel || M_PENABLE !== pen || S_PREADY !== pready || err !== e) begin
            errors++;
            $display("[TB] FAIL %s: got psel=%h pen=%b pready=%h err=%b, expected psel=%h pen=%b pready=%h err=%b",
                     name, M_PSELx, M_PENABLE, S_PREADY, err, psel, pen, pready, e);
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one request from master m and follow it to its S_PREADY within a bounded window.
    task automatic doTransfer(input int m, input logic [DW-1:0] exp_data, input logic exp_err,
                              input int exp_lat, output logic [SP-1:0] seen_psel);
        int  n;
        bit  got;
        n = 0;
        got = 0;
        seen_psel = '0;
        S_PSELx[m] = 1'b1;
        while (n < 30 && !got) begin
            @(negedge clk);
            seen_psel |= M_PSELx;
            if (S_PREADY != '0) got = 1;
            else begin
                n++;
                tick();
            end
        end
        checkValue($sformatf("latency_m%0d", m), n, exp_lat);
        if (got) begin
            checkOutput($sformatf("done_m%0d", m), '0, 1'b0, MP'(1) << m, exp_err);
            checkValue($sformatf("rdata_m%0d", m), S_PRDATA[m*DW +: DW], exp_data);
            tick();
        end
        S_PSELx[m] = 1'b0;
    endtask

    initial begin
        logic [SP-1:0] seen;

        reset    = 1'b0;
        S_PSELx  = '0;
        M_PREADY = '0;
        for (int i = 0; i < MP; i++) begin
            wr[i] = 1'b0;
            wd[i] = DW'(16'h0A00 + i);
        end
        addr[0] = 20'h01000;
        addr[1] = 20'h01005;
        addr[2] = 20'h02000;
        addr[3] = 20'h03000;

        // Contention 0,2,3 repeated; each winner drops for one IDLE then re-requests.
        vecs.push_back(mkv(4'b1101, 6'h3F, 6'h00, 0, 4'b0000, 0));
        vecs.push_back(mkv(4'b1101, 6'h3F, 6'h02, 0, 4'b0000, 0));
        vecs.push_back(mkv(4'b1101, 6'h3F, 6'h02, 1, 4'b0000, 0));
        vecs.push_back(mkv(4'b1101, 6'h3F, 6'h00, 0, 4'b0001, 0));
        vecs.push_back(mkv(4'b1100, 6'h3F, 6'h00, 0, 4'b0000, 0));
        vecs.push_back(mkv(4'b1101, 6'h3F, 6'h04, 0, 4'b0000, 0));
        vecs.push_back(mkv(4'b1101, 6'h3F, 6'h04, 1, 4'b0000, 0));
        vecs.push_back(mkv(4'b1101, 6'h3F, 6'h00, 0, 4'b0100, 0));
        vecs.push_back(mkv(4'b1001, 6'h3F, 6'h00, 0, 4'b0000, 0));
        vecs.push_back(mkv(4'b1101, 6'h3F, 6'h08, 0, 4'b0000, 0));
        vecs.push_back(mkv(4'b1101, 6'h3F, 6'h08, 1, 4'b0000, 0));
        vecs.push_back(mkv(4'b1101, 6'h3F, 6'h00, 0, 4'b1000, 0));
        vecs.push_back(mkv(4'b0101, 6'h3F, 6'h00, 0, 4'b0000, 0));
        vecs.push_back(mkv(4'b1101, 6'h3F, 6'h02, 0, 4'b0000, 0));
        vecs.push_back(mkv(4'b1101, 6'h3F, 6'h02, 1, 4'b0000, 0));
        vecs.push_back(mkv(4'b1101, 6'h3F, 6'h00, 0, 4'b0001, 0));
        vecs.push_back(mkv(4'b1100, 6'h3F, 6'h00, 0, 4'b0000, 0));
        vecs.push_back(mkv(4'b1101, 6'h3F, 6'h04, 0, 4'b0000, 0));
        vecs.push_back(mkv(4'b1101, 6'h3F, 6'h04, 1, 4'b0000, 0));
        vecs.push_back(mkv(4'b1101, 6'h3F, 6'h00, 0, 4'b0100, 0));
        vecs.push_back(mkv(4'b1001, 6'h3F, 6'h00, 0, 4'b0000, 0));
        vecs.push_back(mkv(4'b1000, 6'h3F, 6'h08, 0, 4'b0000, 0));
        vecs.push_back(mkv(4'b1000, 6'h3F, 6'h08, 1, 4'b0000, 0));
        vecs.push_back(mkv(4'b1000, 6'h3F, 6'h00, 0, 4'b1000, 0));
        vecs.push_back(mkv(4'b0000, 6'h3F, 6'h00, 0, 4'b0000, 0));
        // Single zero-wait read by master 1 from slave 1.
        vecs.push_back(mkv(4'b0010, 6'h3F, 6'h00, 0, 4'b0000, 0));
        vecs.push_back(mkv(4'b0010, 6'h3F, 6'h02, 0, 4'b0000, 0));
        vecs.push_back(mkv(4'b0010, 6'h3F, 6'h02, 1, 4'b0000, 0));
        vecs.push_back(mkv(4'b0010, 6'h3F, 6'h00, 0, 4'b0010, 0));
        vecs.push_back(mkv(4'b0000, 6'h3F, 6'h00, 0, 4'b0000, 0));

        repeat (2) @(negedge clk);
        checkOutput("reset_outputs", '0, 1'b0, '0, 1'b0);
        checkValue("reset_paddr", 32'(M_PADDR), 32'h0);
        checkValue("reset_prdata", S_PRDATA[31:0] | S_PRDATA[63:32], 32'h0);
        reset = 1'b1;
        tick();

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("vec%0d", i), vecs[i].psel, vecs[i].pen, vecs[i].pready, vecs[i].err);
            tick();
        end
        checkValue("contend_rdata_m0", 32'(S_PRDATA[0*DW +: DW]), 32'h1234);
        checkValue("contend_rdata_m2", 32'(S_PRDATA[2*DW +: DW]), 32'h2222);
        checkValue("contend_rdata_m3", 32'(S_PRDATA[3*DW +: DW]), 32'h3333);
        checkValue("single_rdata_m1", 32'(S_PRDATA[1*DW +: DW]), 32'h1234);

        // Wait states: master 2 writes slave 3, ready held low for 5 ACCESS cycles.
        addr[2] = 20'h03004; wr[2] = 1'b1; wd[2] = 16'hBEEF;
        M_PREADY = '0;
        S_PSELx  = 4'b0100;
        @(negedge clk); checkOutput("ws_idle", '0, 0, '0, 0); tick();
        @(negedge clk); checkOutput("ws_setup", 6'h08, 0, '0, 0);
        checkValue("ws_setup_paddr", 32'(M_PADDR), 32'h03004); tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("ws_wait", 6'h08, 1, '0, 0);
            checkValue("ws_wait_bus", {11'd0, M_PWRITE, M_PADDR}, {11'd0, 1'b1, 20'h03004});
            checkValue("ws_wait_wdata", 32'(M_PWDATA), 32'hBEEF);
            tick();
        end
        M_PREADY = 6'h08;
        @(negedge clk); checkOutput("ws_ready", 6'h08, 1, '0, 0); tick();
        @(negedge clk); checkOutput("ws_done", '0, 0, 4'b0100, 0);
        checkValue("ws_rdata", 32'(S_PRDATA[2*DW +: DW]), 32'h3333);
        tick();
        S_PSELx = '0; wr[2] = 1'b0;

        // Timeout on slave 2, then a normal transfer.
        addr[3] = 20'h02008;
        M_PREADY = '0;
        doTransfer(3, 16'hDEAD, 1'b1, 10, seen);
        @(negedge clk); checkOutput("to_after_idle", '0, 0, '0, 0); tick();
        M_PREADY = 6'h3F;
        addr[0] = 20'h01000;
        doTransfer(0, 16'h1234, 1'b0, 3, seen);

        // Decode error: slave index 7 beyond 6 slaves.
        addr[1] = 20'h07000; wr[1] = 1'b1;
        doTransfer(1, 16'hDEAD, 1'b1, 1, seen);
        checkValue("dec_no_psel", 32'(seen), 32'h0);
        wr[1] = 1'b0;

        // Exclusive address pass-through, then asynchronous reset during ACCESS.
        addr[1]  = 20'h90004;
        M_PREADY = '0;
        S_PSELx  = 4'b0010;
        @(negedge clk); tick();
        @(negedge clk); checkOutput("ex_setup", 6'h01, 0, '0, 0);
        checkValue("ex_paddr", 32'(M_PADDR), 32'h90004); tick();
        @(negedge clk); checkOutput("ex_access", 6'h01, 1, '0, 0);
        #2 reset = 1'b0;
        #1 checkOutput("rst_async", '0, 0, '0, 0);
        checkValue("rst_async_paddr", 32'(M_PADDR), 32'h0);
        checkValue("rst_prdata_m1", 32'(S_PRDATA[1*DW +: DW]), 32'h0);
        S_PSELx = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        tick();

        // Tie between masters 0 and 3 after reset: master 0 goes first.
        addr[3]  = 20'h03000;
        M_PREADY = 6'h3F;
        S_PSELx  = 4'b1001;
        @(negedge clk); checkOutput("tie_idle", '0, 0, '0, 0); tick();
        @(negedge clk); checkOutput("tie_setup_m0", 6'h02, 0, '0, 0); tick();
        @(negedge clk); tick();
        @(negedge clk); checkOutput("tie_done_m0", '0, 0, 4'b0001, 0); tick();
        S_PSELx = 4'b1000;
        doTransfer(3, 16'h3333, 1'b0, 3, seen);
        checkValue("tie_m3_psel", 32'(seen), 32'h08);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
